// File: rtl/walk_pkg.sv
// Shared definitions for the walk-request path: server state encoding,
// lamp-pair constants and a small state classification helper.
package walk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WALK  = 3'd2,
    ST_FLASH = 3'd3,
    ST_CLEAR = 3'd4,
    ST_GAP   = 3'd5
  } walk_state_e;

  typedef struct packed {
    logic walk;
    logic dont_walk;
  } lamp_t;

  localparam lamp_t LAMP_WALK      = '{walk: 1'b1, dont_walk: 1'b0};
  localparam lamp_t LAMP_DONT_WALK = '{walk: 1'b0, dont_walk: 1'b1};

  // States whose duration is measured in ticks by the down counter.
  function automatic logic is_timed(input walk_state_e s);
    return (s == ST_WALK) || (s == ST_FLASH) || (s == ST_GAP);
  endfunction

endpackage

// File: rtl/tick_down_counter.sv
// Loadable down counter advanced by a tick enable; saturates at zero.
module tick_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             tick,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // A load on the same edge as a tick wins, so the entry tick is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/walk_request_server.sv
// Serves latched pedestrian requests: negotiates an all-red window with the
// traffic FSM, runs WALK / flashing DON'T WALK, and clears the walk register.
module walk_request_server
  import walk_pkg::*;
#(
  parameter int WALK_TIME  = 4,
  parameter int FLASH_TIME = 3,
  parameter int GAP_TIME   = 2,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic Reset_n,
  input  logic tick,
  input  logic WR_Status,
  input  logic Stop_Ack,
  output logic WR_Reset,
  output logic Stop_Req,
  output logic Walk_Lamp,
  output logic Dont_Walk_Lamp,
  output logic Busy
);

  localparam logic [CNT_W-1:0] WALK_LOAD  = CNT_W'(WALK_TIME - 1);
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_TIME - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_TIME - 1);

  walk_state_e      state;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_tick;
  logic             cnt_zero;

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      ST_REQ: begin
        if (WR_Status && Stop_Ack) begin
          cnt_load = 1'b1;
          cnt_val  = WALK_LOAD;
        end
      end
      ST_WALK: begin
        if (Stop_Ack && tick && cnt_zero) begin
          cnt_load = 1'b1;
          cnt_val  = FLASH_LOAD;
        end
      end
      ST_CLEAR: begin
        cnt_load = 1'b1;
        cnt_val  = GAP_LOAD;
      end
      default: ;
    endcase
  end

  assign cnt_tick = tick && is_timed(state);

  tick_down_counter #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (Reset_n),
    .load    (cnt_load),
    .load_val(cnt_val),
    .tick    (cnt_tick),
    .zero    (cnt_zero)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state                       <= ST_IDLE;
      WR_Reset                    <= 1'b0;
      Stop_Req                    <= 1'b0;
      {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_DONT_WALK;
      Busy                        <= 1'b0;
    end else begin
      WR_Reset <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (WR_Status) begin
            state    <= ST_REQ;
            Stop_Req <= 1'b1;
            Busy     <= 1'b1;
          end
        end
        ST_REQ: begin
          // An external clear of the walk register withdraws the request.
          if (!WR_Status) begin
            state    <= ST_IDLE;
            Stop_Req <= 1'b0;
            Busy     <= 1'b0;
          end else if (Stop_Ack) begin
            state                       <= ST_WALK;
            WR_Reset                    <= 1'b1;
            {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_WALK;
          end
        end
        ST_WALK: begin
          if (!Stop_Ack) begin
            state                       <= ST_CLEAR;
            Stop_Req                    <= 1'b0;
            {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_DONT_WALK;
          end else if (tick && cnt_zero) begin
            state                       <= ST_FLASH;
            {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_DONT_WALK;
          end
        end
        ST_FLASH: begin
          if (!Stop_Ack) begin
            state                       <= ST_CLEAR;
            Stop_Req                    <= 1'b0;
            {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_DONT_WALK;
          end else if (tick) begin
            if (cnt_zero) begin
              state          <= ST_CLEAR;
              Stop_Req       <= 1'b0;
              Dont_Walk_Lamp <= 1'b1;
            end else begin
              Dont_Walk_Lamp <= ~Dont_Walk_Lamp;
            end
          end
        end
        ST_CLEAR: begin
          state <= ST_GAP;
        end
        ST_GAP: begin
          if (tick && cnt_zero) begin
            state <= ST_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state                       <= ST_IDLE;
          Stop_Req                    <= 1'b0;
          {Walk_Lamp, Dont_Walk_Lamp} <= LAMP_DONT_WALK;
          Busy                        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_walk_request_server.sv
// Self-checking bench: a behavioural model feeds an expected-output queue for
// the default-parameter instance; a vector table drives a 1/1/1 instance.
module tb_walk_request_server;
  import walk_pkg::*;

  localparam int WT = 4;
  localparam int FT = 3;
  localparam int GT = 2;

  typedef struct packed {
    logic wr_reset;
    logic stop_req;
    logic walk;
    logic dont_walk;
    logic busy;
  } outs_t;

  typedef struct {
    logic  wr;
    logic  ack;
    logic  tk;
    outs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic Reset_n;
  logic tick, WR_Status, Stop_Ack;
  logic WR_Reset, Stop_Req, Walk_Lamp, Dont_Walk_Lamp, Busy;
  logic c_tick, c_wr, c_ack;
  logic c_wr_reset, c_stop_req, c_walk, c_dont_walk, c_busy;

  walk_request_server dut (
    .clk           (clk),
    .Reset_n       (Reset_n),
    .tick          (tick),
    .WR_Status     (WR_Status),
    .Stop_Ack      (Stop_Ack),
    .WR_Reset      (WR_Reset),
    .Stop_Req      (Stop_Req),
    .Walk_Lamp     (Walk_Lamp),
    .Dont_Walk_Lamp(Dont_Walk_Lamp),
    .Busy          (Busy)
  );

  walk_request_server #(
    .WALK_TIME (1),
    .FLASH_TIME(1),
    .GAP_TIME  (1),
    .CNT_W     (8)
  ) dut_min (
    .clk           (clk),
    .Reset_n       (Reset_n),
    .tick          (c_tick),
    .WR_Status     (c_wr),
    .Stop_Ack      (c_ack),
    .WR_Reset      (c_wr_reset),
    .Stop_Req      (c_stop_req),
    .Walk_Lamp     (c_walk),
    .Dont_Walk_Lamp(c_dont_walk),
    .Busy          (c_busy)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int tick_period  = 4;
  int tick_cnt     = 0;
  int pulses       = 0;
  int walk_hi      = 0;
  int stall_bad    = 0;

  outs_t exp_q[$];
  outs_t obs;

  walk_state_e m_phase;
  int          m_left;
  logic        m_dw;
  logic        m_pulse;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic outs_t dut_outs();
    return outs_t'({WR_Reset, Stop_Req, Walk_Lamp, Dont_Walk_Lamp, Busy});
  endfunction

  function automatic outs_t min_outs();
    return outs_t'({c_wr_reset, c_stop_req, c_walk, c_dont_walk, c_busy});
  endfunction

  task automatic model_reset();
    m_phase = ST_IDLE;
    m_left  = 0;
    m_dw    = 1'b1;
    m_pulse = 1'b0;
  endtask

  // Tracks ticks still owed to the current phase rather than a zero-based count.
  task automatic model_step(input logic wr, input logic ack, input logic tk);
    m_pulse = 1'b0;
    case (m_phase)
      ST_IDLE: if (wr) m_phase = ST_REQ;
      ST_REQ: begin
        if (!wr) m_phase = ST_IDLE;
        else if (ack) begin
          m_phase = ST_WALK;
          m_left  = WT;
          m_pulse = 1'b1;
        end
      end
      ST_WALK: begin
        if (!ack) m_phase = ST_CLEAR;
        else if (tk) begin
          m_left--;
          if (m_left == 0) begin
            m_phase = ST_FLASH;
            m_left  = FT;
            m_dw    = 1'b1;
          end
        end
      end
      ST_FLASH: begin
        if (!ack) m_phase = ST_CLEAR;
        else if (tk) begin
          m_left--;
          if (m_left == 0) m_phase = ST_CLEAR;
          else m_dw = !m_dw;
        end
      end
      ST_CLEAR: begin
        m_phase = ST_GAP;
        m_left  = GT;
      end
      ST_GAP: begin
        if (tk) begin
          m_left--;
          if (m_left == 0) m_phase = ST_IDLE;
        end
      end
      default: m_phase = ST_IDLE;
    endcase
  endtask

  function automatic outs_t model_outs();
    outs_t o;
    o.wr_reset  = m_pulse;
    o.stop_req  = (m_phase == ST_REQ) || (m_phase == ST_WALK) || (m_phase == ST_FLASH);
    o.walk      = (m_phase == ST_WALK);
    o.dont_walk = (m_phase == ST_WALK) ? 1'b0 : (m_phase == ST_FLASH) ? m_dw : 1'b1;
    o.busy      = (m_phase != ST_IDLE);
    return o;
  endfunction

  // One clock of the main instance: drive at negedge, predict, compare after posedge.
  task automatic cycle(input logic wr, input logic ack);
    logic tk;
    @(negedge clk);
    tk       = (tick_cnt == tick_period - 1);
    tick_cnt = tk ? 0 : tick_cnt + 1;
    WR_Status = wr;
    Stop_Ack  = ack;
    tick      = tk;
    model_step(wr, ack, tk);
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    obs = dut_outs();
    check("model_step", 32'(obs), 32'(exp_q.pop_front()));
    pulses  += int'(obs.wr_reset);
    walk_hi += int'(obs.walk);
  endtask

  function automatic vec_t mk(input logic wr, input logic ack, input logic tk, input logic [4:0] e);
    vec_t v;
    v.wr  = wr;
    v.ack = ack;
    v.tk  = tk;
    v.exp = outs_t'(e);
    return v;
  endfunction

  vec_t  vecs[15];
  outs_t min_q[$];

  initial begin
    // Expected outputs of the 1/1/1 instance: {WR_Reset,Stop_Req,Walk,DontWalk,Busy}.
    vecs[0]  = mk(1, 0, 1, 5'b01011);
    vecs[1]  = mk(1, 1, 1, 5'b11101);
    vecs[2]  = mk(0, 1, 1, 5'b01011);
    vecs[3]  = mk(0, 1, 1, 5'b00011);
    vecs[4]  = mk(0, 0, 1, 5'b00011);
    vecs[5]  = mk(0, 0, 1, 5'b00010);
    vecs[6]  = mk(0, 0, 0, 5'b00010);
    vecs[7]  = mk(1, 0, 0, 5'b01011);
    vecs[8]  = mk(0, 0, 0, 5'b00010);
    vecs[9]  = mk(1, 0, 0, 5'b01011);
    vecs[10] = mk(1, 1, 0, 5'b11101);
    vecs[11] = mk(0, 0, 0, 5'b00011);
    vecs[12] = mk(0, 0, 0, 5'b00011);
    vecs[13] = mk(0, 0, 0, 5'b00011);
    vecs[14] = mk(0, 0, 1, 5'b00010);

    Reset_n   = 1'b0;
    tick      = 1'b0;
    WR_Status = 1'b0;
    Stop_Ack  = 1'b0;
    c_tick    = 1'b0;
    c_wr      = 1'b0;
    c_ack     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_main", 32'(dut_outs()), 'b00010);
    check("reset_min", 32'(min_outs()), 'b00010);
    Reset_n = 1'b1;

    // Basic walk with a tick every 4 clocks, entry edge aligned to a tick.
    cycle(1, 0);
    check("basic_req", 32'({Stop_Req, Busy}), 'b11);
    cycle(1, 0);
    cycle(1, 0);
    tick_cnt = tick_period - 1;
    pulses   = 0;
    walk_hi  = 0;
    cycle(1, 1);
    check("basic_wr_reset", 32'(WR_Reset), 1);
    repeat (15) cycle(0, 1);
    check("basic_walk_clks", 32'(walk_hi), 16);
    cycle(0, 1);
    check("flash_dw_tick0", 32'({Walk_Lamp, Dont_Walk_Lamp}), 'b01);
    repeat (4) cycle(0, 1);
    check("flash_dw_tick1", 32'(Dont_Walk_Lamp), 0);
    repeat (4) cycle(0, 1);
    check("flash_dw_tick2", 32'(Dont_Walk_Lamp), 1);
    repeat (4) cycle(0, 1);
    check("clear_state", 32'({Stop_Req, Dont_Walk_Lamp, Busy}), 'b011);
    repeat (7) cycle(0, 0);
    check("gap_busy", 32'(Busy), 1);
    cycle(0, 0);
    check("gap_to_idle", 32'(Busy), 0);
    check("basic_single_pulse", 32'(pulses), 1);

    // Acknowledge stall: REQ held for 50 clocks, then the request is withdrawn.
    pulses = 0;
    cycle(1, 0);
    stall_bad = 0;
    repeat (50) begin
      cycle(1, 0);
      if (dut_outs() !== outs_t'(5'b01011)) stall_bad++;
    end
    check("stall_req_held", 32'(stall_bad), 0);
    cycle(0, 0);
    check("req_withdraw", 32'({Stop_Req, Busy}), 0);
    check("stall_no_pulse", 32'(pulses), 0);

    // Abort after two WALK ticks.
    cycle(1, 0);
    cycle(1, 0);
    tick_cnt = tick_period - 1;
    pulses   = 0;
    cycle(1, 1);
    repeat (8) cycle(0, 1);
    check("abort_still_walking", 32'(Walk_Lamp), 1);
    cycle(0, 0);
    check("abort_clear", 32'({Stop_Req, Walk_Lamp, Dont_Walk_Lamp, Busy}), 'b0011);
    cycle(0, 0);
    check("abort_gap_busy", 32'(Busy), 1);
    repeat (10) cycle(0, 0);
    check("abort_idle", 32'(Busy), 0);
    check("abort_single_pulse", 32'(pulses), 1);

    // Back-to-back: a new request latched during FLASH is served after GAP.
    cycle(1, 0);
    cycle(1, 0);
    tick_cnt = tick_period - 1;
    pulses   = 0;
    cycle(1, 1);
    repeat (16) cycle(0, 1);
    repeat (12) cycle(1, 1);
    repeat (7) cycle(1, 0);
    cycle(1, 0);
    check("b2b_idle", 32'(Busy), 0);
    cycle(1, 0);
    check("b2b_req_one_clk", 32'({Stop_Req, Busy}), 'b11);
    tick_cnt = tick_period - 1;
    cycle(1, 1);
    check("b2b_second_pulse", 32'(WR_Reset), 1);
    check("b2b_pulse_count", 32'(pulses), 2);
    cycle(0, 0);
    repeat (12) cycle(0, 0);
    check("b2b_done", 32'(Busy), 0);

    // Asynchronous reset in the middle of FLASH.
    cycle(1, 0);
    tick_cnt = tick_period - 1;
    cycle(1, 1);
    repeat (18) cycle(0, 1);
    check("pre_reset_flash", 32'({Walk_Lamp, Busy}), 'b01);
    #3;
    Reset_n = 1'b0;
    #1;
    check("reset_async", 32'(dut_outs()), 'b00010);
    model_reset();
    @(posedge clk);
    #1;
    check("reset_held", 32'(dut_outs()), 'b00010);
    @(negedge clk);
    WR_Status = 1'b0;
    Stop_Ack  = 1'b0;
    tick      = 1'b0;
    Reset_n   = 1'b1;
    cycle(0, 0);
    check("post_reset_idle", 32'({Busy, Dont_Walk_Lamp}), 'b01);

    // Random stream against the model, faster tick.
    tick_period = 2;
    tick_cnt    = 0;
    for (int i = 0; i < 300; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 7) != 0));
    end
    repeat (10) cycle(0, 0);

    // Minimum-parameter instance, tick every clock, vector table.
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      c_wr   = vecs[i].wr;
      c_ack  = vecs[i].ack;
      c_tick = vecs[i].tk;
      min_q.push_back(vecs[i].exp);
      @(posedge clk);
      #1;
      check($sformatf("min_vec%0d", i), 32'(min_outs()), 32'(min_q.pop_front()));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/walk_request_server.md
Name: walk_request_server

Overview:
- Consumer end of the walk-request path: watches the latched pedestrian request (WR_Status) from the walk register and negotiates an all-red window with the main traffic controller.
- Sequences the pedestrian lamps through WALK and flashing DON'T WALK.
- Clears the walk register by pulsing WR_Reset.
- Sits between the walk register and the main traffic-light FSM.

Parameters:
- WALK_TIME, 4, number of ticks the steady WALK lamp is lit (must be ≥1).
- FLASH_TIME, 3, number of ticks of flashing DON'T WALK (must be ≥1).
- GAP_TIME, 2, minimum ticks after release before the next request is served (must be ≥1).
- CNT_W, 8, timer width; must hold max(WALK_TIME, FLASH_TIME, GAP_TIME)-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe); all phase timing counts ticks only.
- WR_Status  in  1  latched walk request from the walk register.
- Stop_Ack  in  1  level from the traffic FSM: main road held all-red.
- WR_Reset  out  1  one-clk active-high pulse that clears the walk register.
- Stop_Req  out  1  level request to the traffic FSM to hold all-red.
- Walk_Lamp  out  1  steady WALK indication.
- Dont_Walk_Lamp  out  1  DON'T WALK indication (steady or flashing).
- Busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values (async, while Reset_n=0):
  - state=IDLE, counter=0.
  - WR_Reset=0, Stop_Req=0, Walk_Lamp=0, Dont_Walk_Lamp=1, Busy=0.
- States: IDLE, REQ, WALK, FLASH, CLEAR, GAP.
- IDLE:
  - Stop_Req=0, Dont_Walk_Lamp=1.
  - WR_Status=1 → REQ on the next clk (one-cycle latency), independent of tick.
- REQ:
  - Stop_Req=1.
  - Waits indefinitely for Stop_Ack=1, then → WALK.
  - On that same transition edge, WR_Reset pulses high for exactly one clk.
  - Counter loads WALK_TIME-1.
- WALK:
  - Walk_Lamp=1, Dont_Walk_Lamp=0, Stop_Req=1.
  - On each tick: if counter==0 → FLASH (counter loads FLASH_TIME-1); else counter decrements.
  - Phase lasts exactly WALK_TIME ticks.
- FLASH:
  - Walk_Lamp=0; Dont_Walk_Lamp toggles on each tick, starting at 1 on entry.
  - Counting rule is the same as WALK; after FLASH_TIME ticks → CLEAR.
- CLEAR:
  - Single clk: Stop_Req drops to 0, Dont_Walk_Lamp=1 steady, counter loads GAP_TIME-1.
  - → GAP.
- GAP:
  - Stop_Req=0, Dont_Walk_Lamp=1.
  - Counts GAP_TIME ticks, then → IDLE.
  - WR_Status may already be 1 (request latched during WALK/FLASH/GAP); IDLE then forwards to REQ next clk.
- Stop_Ack deasserted during WALK or FLASH (traffic FSM override): abort → CLEAR next clk, Walk_Lamp=0 immediately on that edge. No second WR_Reset; the request is considered served.
- Stop_Ack in IDLE/GAP/CLEAR is ignored.
- WR_Status dropping during REQ (external clear) → IDLE, Stop_Req=0, no WR_Reset.
- Simultaneous tick and state-entry edge: the entry edge loads the counter; that tick is not counted.
- Counter never wraps: it decrements only when nonzero.
- Walk_Lamp and Dont_Walk_Lamp are never 1 together.
- Reset_n asserted mid-phase: immediate return to reset values. Lamps go to DON'T WALK steady; no WR_Reset pulse is emitted.

Decomposition:
- Shared package/header `walk_pkg`: state encoding localparams (IDLE..GAP, 3 bits) and lamp-state constants, reused by the walk register and traffic FSM benches.
- One natural sub-module: `tick_down_counter` (CNT_W, load value, tick enable, zero flag). Instantiated once in the server and reusable by the main traffic FSM.

Test Plan:
- Basic walk, tick every 4 clk (defaults):
  - Drive WR_Status=1, then Stop_Ack=1 three clk after Stop_Req rises.
  - Require WR_Reset single pulse on the WALK-entry edge.
  - Require Walk_Lamp=1 for 16 clk, then Dont_Walk_Lamp pattern 1,0,1 per tick.
  - Require Stop_Req=0 in CLEAR, then IDLE after 2 ticks.
- Ack stall: hold Stop_Ack=0 for 50 clk → state stays REQ, Stop_Req=1, WR_Reset=0 throughout, lamps DON'T WALK.
- Abort: Stop_Ack drops after 2 WALK ticks → Walk_Lamp=0 next edge, CLEAR, then GAP, no extra WR_Reset.
- Back-to-back: WR_Status re-asserted during FLASH → after GAP of 2 ticks, IDLE→REQ in one clk; second WR_Reset issued at second WALK entry.
- Reset mid-FLASH: Reset_n=0 asynchronously between edges → outputs go to reset values immediately; after release, IDLE with Busy=0.
- Parameter corner, WALK_TIME=1, FLASH_TIME=1, GAP_TIME=1, tick every clk → WALK 1 clk, FLASH 1 clk with Dont_Walk_Lamp=1, CLEAR 1 clk, GAP 1 clk.
